// File: rtl/ddr3_traffic_checker.sv
// DDR3 write/read-back traffic checker: writes a patterned region, reads it back and scores every word.
// First command one cycle after start; commands held until ctrl_ready, reads throttled at MAX_OUTSTANDING.
module ddr3_traffic_checker #(
  parameter int          ADDRESS_BITWIDTH      = 15,
  parameter int          BANK_ADDRESS_BITWIDTH = 3,
  parameter int          DQ_BITWIDTH           = 16,
  parameter int          NUM_WORDS             = 1024,
  parameter int unsigned BASE_ADDRESS          = 0,
  parameter int          MAX_OUTSTANDING       = 4,
  parameter logic [15:0] LFSR_SEED             = 16'hACE1,
  parameter int          TIMEOUT_CYCLES        = 4096
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              start,
  input  logic [1:0]                                        pattern_sel,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            i_user_data,
  input  logic                                              ctrl_ready,
  input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
  input  logic                                              o_user_data_valid,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              timeout,
  output logic [15:0]                                       error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int IW = $clog2(NUM_WORDS) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t         state;
  logic [1:0]     sel_q;
  logic [IW-1:0]  wr_idx;
  logic [IW-1:0]  rd_idx;
  logic [IW-1:0]  exp_idx;
  logic [15:0]    wr_lfsr;
  logic [15:0]    exp_lfsr;
  logic [3:0]     outstanding;
  logic [TW-1:0]  tmo_cnt;
  logic           err_seen;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [DQ_BITWIDTH-1:0] pattern(input logic [1:0] sel,
                                                     input logic [IW-1:0] idx,
                                                     input logic [15:0] lf);
    logic [31:0]             idx32;
    logic [DQ_BITWIDTH-1:0]  inc;
    idx32 = 32'(idx);
    inc   = DQ_BITWIDTH'(idx32);
    case (sel)
      2'd0:    return inc;
      2'd1:    return ~inc;
      2'd2:    return DQ_BITWIDTH'(1) << (idx32 % 32'(DQ_BITWIDTH));
      default: return DQ_BITWIDTH'(lf);
    endcase
  endfunction

  // Region wraps modulo the full bank+row/col address space.
  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] idx);
    return AW'(BASE_ADDRESS + 32'(idx));
  endfunction

  logic          wr_xfer;
  logic          rd_xfer;
  logic          in_rd_phase;
  logic          rsp_acc;
  logic          mismatch;
  logic [3:0]    out_nxt;
  logic [IW-1:0] rd_idx_nxt;
  logic [15:0]   err_nxt;
  logic          tmo_hit;

  assign wr_xfer     = write_enable & ctrl_ready;
  assign rd_xfer     = read_enable & ctrl_ready;
  assign in_rd_phase = (state == S_READ) || (state == S_DRAIN);
  assign rsp_acc     = o_user_data_valid && in_rd_phase && (outstanding != 4'd0);
  assign mismatch    = rsp_acc && (o_user_data != pattern(sel_q, exp_idx, exp_lfsr));
  assign out_nxt     = outstanding + 4'(rd_xfer) - 4'(rsp_acc);
  assign rd_idx_nxt  = rd_idx + IW'(rd_xfer);
  assign err_nxt     = (mismatch && error_count != 16'hFFFF) ? error_count + 16'd1 : error_count;
  assign tmo_hit     = in_rd_phase && (outstanding != 4'd0) && !o_user_data_valid &&
                       (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= S_IDLE;
      sel_q               <= 2'd0;
      wr_idx              <= '0;
      rd_idx              <= '0;
      exp_idx             <= '0;
      wr_lfsr             <= LFSR_SEED;
      exp_lfsr            <= LFSR_SEED;
      outstanding         <= 4'd0;
      tmo_cnt             <= '0;
      err_seen            <= 1'b0;
      write_enable        <= 1'b0;
      read_enable         <= 1'b0;
      i_user_data_address <= '0;
      i_user_data         <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      error_count         <= 16'd0;
      first_error_address <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state               <= S_WRITE;
            sel_q               <= pattern_sel;
            wr_idx              <= '0;
            rd_idx              <= '0;
            exp_idx             <= '0;
            wr_lfsr             <= LFSR_SEED;
            exp_lfsr            <= LFSR_SEED;
            outstanding         <= 4'd0;
            tmo_cnt             <= '0;
            err_seen            <= 1'b0;
            write_enable        <= 1'b1;
            i_user_data_address <= addr_of('0);
            i_user_data         <= pattern(pattern_sel, '0, LFSR_SEED);
            busy                <= 1'b1;
            done                <= 1'b0;
            pass                <= 1'b0;
            timeout             <= 1'b0;
            error_count         <= 16'd0;
            first_error_address <= '0;
          end
        end
        S_WRITE: begin
          if (wr_xfer) begin
            if (wr_idx == IW'(NUM_WORDS - 1)) begin
              state               <= S_READ;
              write_enable        <= 1'b0;
              read_enable         <= 1'b1;
              i_user_data_address <= addr_of('0);
              i_user_data         <= '0;
            end else begin
              wr_idx              <= wr_idx + IW'(1);
              wr_lfsr             <= lfsr_step(wr_lfsr);
              i_user_data_address <= addr_of(wr_idx + IW'(1));
              i_user_data         <= pattern(sel_q, wr_idx + IW'(1), lfsr_step(wr_lfsr));
            end
          end
        end
        S_READ: begin
          rd_idx <= rd_idx_nxt;
          if (rd_xfer)
            i_user_data_address <= addr_of(rd_idx_nxt);
          // Registered throttle: only raise read_enable when the next cycle still has a free slot.
          read_enable <= (rd_idx_nxt != IW'(NUM_WORDS)) && (out_nxt < 4'(MAX_OUTSTANDING));
          if (rd_idx_nxt == IW'(NUM_WORDS))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_nxt == 4'd0) begin
            state   <= S_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (err_nxt == 16'd0);
            tmo_cnt <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (in_rd_phase) begin
        outstanding <= out_nxt;
        error_count <= err_nxt;
        if (rsp_acc) begin
          exp_idx  <= exp_idx + IW'(1);
          exp_lfsr <= lfsr_step(exp_lfsr);
        end
        if (mismatch && !err_seen) begin
          err_seen            <= 1'b1;
          first_error_address <= addr_of(exp_idx);
        end
        if (o_user_data_valid || outstanding == 4'd0)
          tmo_cnt <= '0;
        else
          tmo_cnt <= tmo_cnt + TW'(1);
        if (tmo_hit) begin
          state       <= S_DONE;
          timeout     <= 1'b1;
          done        <= 1'b1;
          busy        <= 1'b0;
          pass        <= 1'b0;
          read_enable <= 1'b0;
          tmo_cnt     <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Scoreboard bench for ddr3_traffic_checker: a region that wraps the top of the address space,
// a behavioural controller/memory, and expected commands/results queued per run.
module tb_ddr3_traffic_checker;

  localparam int          AW   = 18;
  localparam int          DQ   = 16;
  localparam int          NW   = 8;
  localparam int          MAXO = 4;
  localparam int          TMO  = 64;
  localparam int unsigned BASE = 262140;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    pattern_sel;
  logic          write_enable;
  logic          read_enable;
  logic [AW-1:0] i_user_data_address;
  logic [DQ-1:0] i_user_data;
  logic          ctrl_ready;
  logic [DQ-1:0] o_user_data;
  logic          o_user_data_valid;
  logic          busy;
  logic          done;
  logic          pass;
  logic          timeout;
  logic [15:0]   error_count;
  logic [AW-1:0] first_error_address;

  always #5 clk = ~clk;

  ddr3_traffic_checker #(
    .ADDRESS_BITWIDTH(15), .BANK_ADDRESS_BITWIDTH(3), .DQ_BITWIDTH(DQ),
    .NUM_WORDS(NW), .BASE_ADDRESS(BASE), .MAX_OUTSTANDING(MAXO),
    .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pattern_sel(pattern_sel),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .i_user_data(i_user_data),
    .ctrl_ready(ctrl_ready), .o_user_data(o_user_data), .o_user_data_valid(o_user_data_valid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .first_error_address(first_error_address)
  );

  typedef struct { logic [AW-1:0] addr; logic [DQ-1:0] data; } wr_t;
  typedef struct { logic p; logic [15:0] errs; logic [AW-1:0] fea; logic tmo; } res_t;
  typedef struct { int due; logic [DQ-1:0] d; } rsp_t;

  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_rd_q[$];
  res_t          exp_res_q[$];
  rsp_t          pipe[$];
  logic [DQ-1:0] mem [logic [AW-1:0]];

  // Hand-derived Galois sequence (taps 0xB400) starting from seed 0xACE1.
  logic [15:0] lfsr_tab [NW] = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C,
                                 16'h1C4E, 16'h0E27, 16'hB313, 16'hED89};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic ready_toggle = 1'b0;
  int lat = 3;
  int flip_addr = -1;
  int stop_after = 1000;
  int nreads = 0;
  int tb_out = 0;
  int last_valid_cyc = 0;
  int done_cyc = 0;
  int runs_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DQ-1:0] exp_data(input logic [1:0] sel, input int i);
    logic [DQ-1:0] v;
    v = DQ'(i);
    case (sel)
      2'd0:    return v;
      2'd1:    return ~v;
      2'd2:    return DQ'(1) << i;
      default: return lfsr_tab[i];
    endcase
  endfunction

  // Behavioural controller: ready pattern, memory, fixed-latency in-order read returns.
  initial begin
    ctrl_ready = 1'b0;
    o_user_data = '0;
    o_user_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        ctrl_ready = 1'b0;
        o_user_data_valid = 1'b0;
        pipe.delete();
      end else begin
        ctrl_ready = ready_toggle ? (cyc % 2 == 1) : 1'b1;
        if (pipe.size() > 0 && pipe[0].due <= cyc) begin
          o_user_data = pipe[0].d;
          o_user_data_valid = 1'b1;
          void'(pipe.pop_front());
          last_valid_cyc = cyc;
        end else begin
          o_user_data_valid = 1'b0;
        end
        if (write_enable && ctrl_ready)
          mem[i_user_data_address] = i_user_data;
        if (read_enable && ctrl_ready) begin
          logic [DQ-1:0] dd;
          nreads++;
          if (nreads <= stop_after) begin
            dd = mem.exists(i_user_data_address) ? mem[i_user_data_address] : '0;
            if (int'(i_user_data_address) == flip_addr) dd[0] = ~dd[0];
            pipe.push_back('{due: cyc + lat, d: dd});
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every command transfer and on each rising done.
  initial begin
    logic          prev_stall = 1'b0;
    logic          prev_done = 1'b0;
    logic [1:0]    prev_en = 2'b00;
    logic [AW-1:0] prev_addr = '0;
    logic [DQ-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        prev_stall = 1'b0;
        prev_done = 1'b0;
        continue;
      end
      if (write_enable || read_enable)
        chk("single_enable", {31'd0, write_enable & read_enable}, 32'd0);
      if (prev_stall) begin
        chk("hold_enable", {30'd0, write_enable, read_enable}, {30'd0, prev_en});
        chk("hold_address", 32'(i_user_data_address), 32'(prev_addr));
        if (prev_en == 2'b10) chk("hold_data", 32'(i_user_data), 32'(prev_data));
      end
      prev_stall = (write_enable || read_enable) && !ctrl_ready;
      prev_en = {write_enable, read_enable};
      prev_addr = i_user_data_address;
      prev_data = i_user_data;
      if (write_enable && ctrl_ready) begin
        if (exp_wr_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          chk("write_address", 32'(i_user_data_address), 32'(e.addr));
          chk("write_data", 32'(i_user_data), 32'(e.data));
        end
      end
      if (read_enable && ctrl_ready) begin
        tb_out++;
        chk("outstanding_max", {31'd0, tb_out <= MAXO}, 32'd1);
        if (exp_rd_q.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
        else chk("read_address", 32'(i_user_data_address), 32'(exp_rd_q.pop_front()));
      end
      if (o_user_data_valid && tb_out > 0) tb_out--;
      if (done && !prev_done) begin
        runs_done++;
        done_cyc = cyc;
        if (exp_res_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          res_t r;
          r = exp_res_q.pop_front();
          chk("pass", {31'd0, pass}, {31'd0, r.p});
          chk("error_count", {16'd0, error_count}, {16'd0, r.errs});
          chk("first_error_address", 32'(first_error_address), 32'(r.fea));
          chk("timeout", {31'd0, timeout}, {31'd0, r.tmo});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
      end
      prev_done = done;
    end
  end

  task automatic push_cmds(input logic [1:0] sel);
    for (int i = 0; i < NW; i++) begin
      exp_wr_q.push_back('{addr: AW'(BASE + i), data: exp_data(sel, i)});
      exp_rd_q.push_back(AW'(BASE + i));
    end
  endtask

  task automatic pulse_start(input logic [1:0] sel);
    @(negedge clk);
    pattern_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency_we", {31'd0, write_enable}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic run(input logic [1:0] sel, input logic tog, input int l, input int flip,
                     input int stop, input logic busy_starts, input logic ep,
                     input logic [15:0] eerr, input logic [AW-1:0] efea, input logic etmo);
    int n0;
    ready_toggle = tog;
    lat = l;
    flip_addr = flip;
    stop_after = stop;
    nreads = 0;
    tb_out = 0;
    push_cmds(sel);
    exp_res_q.push_back('{p: ep, errs: eerr, fea: efea, tmo: etmo});
    n0 = runs_done;
    pulse_start(sel);
    if (busy_starts) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        pattern_sel = sel + 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    for (int i = 0; i < 3000 && runs_done == n0; i++) @(negedge clk);
    #3;
    chk("run_completed", {31'd0, runs_done != n0}, 32'd1);
    chk("writes_consumed", 32'(exp_wr_q.size()), 32'd0);
    chk("reads_consumed", 32'(exp_rd_q.size()), 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_res_q.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_write_enable", {31'd0, write_enable}, 32'd0);
    chk("rst_read_enable", {31'd0, read_enable}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_error_count", {16'd0, error_count}, 32'd0);
    chk("rst_first_error_address", 32'(first_error_address), 32'd0);
    chk("rst_address", 32'(i_user_data_address), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Incrementing pattern, ideal controller; region wraps 3FFFC..3FFFF,0..3.
    run(2'd0, 1'b0, 3, -1, 1000, 1'b0, 1'b1, 16'd0, '0, 1'b0);
    // Inverted pattern with bit0 corrupted at address 1 (word index 5).
    run(2'd1, 1'b0, 3, 1, 1000, 1'b0, 1'b0, 16'd1, AW'(1), 1'b0);
    // Walking one, ready toggling every cycle, long read latency.
    run(2'd2, 1'b1, 20, -1, 1000, 1'b0, 1'b1, 16'd0, '0, 1'b0);
    // Controller drops the 8th read response.
    run(2'd0, 1'b0, 3, -1, 7, 1'b0, 1'b0, 16'd0, '0, 1'b1);
    chk("timeout_delay_max", {31'd0, (done_cyc - last_valid_cyc) <= TMO + 1}, 32'd1);
    chk("timeout_delay_min", {31'd0, (done_cyc - last_valid_cyc) >= TMO - 1}, 32'd1);

    // Abort a run during READ with an asynchronous reset.
    ready_toggle = 1'b0;
    lat = 3;
    flip_addr = -1;
    stop_after = 1000;
    nreads = 0;
    tb_out = 0;
    push_cmds(2'd0);
    pulse_start(2'd0);
    for (int i = 0; i < 200 && !read_enable; i++) @(negedge clk);
    chk("reached_read", {31'd0, read_enable}, 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_read_enable", {31'd0, read_enable}, 32'd0);
    chk("async_rst_write_enable", {31'd0, write_enable}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_wr_q.delete();
    exp_rd_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    // Clean LFSR rerun with extra start pulses while busy.
    run(2'd3, 1'b0, 3, -1, 1000, 1'b1, 1'b1, 16'd0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
